// File: rtl/ucca_pkg.sv
// Shared definitions for the UCCA monitor: cause codes, default
// configuration window bounds and the per-region state encoding.
package ucca_pkg;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_CFG   = 3'd1;
    localparam logic [2:0] CAUSE_ENTRY = 3'd2;
    localparam logic [2:0] CAUSE_EXIT  = 3'd3;
    localparam logic [2:0] CAUSE_IRQ   = 3'd4;
    localparam logic [2:0] CAUSE_STACK = 3'd5;

    localparam logic [15:0] META_MIN_DEFAULT = 16'h0140;
    localparam logic [15:0] META_MAX_DEFAULT = 16'h016A;

    typedef enum logic {
        OUTSIDE = 1'b0,
        INSIDE  = 1'b1
    } region_state_e;

endpackage

// File: rtl/ucca_region_fsm.sv
// Entry/exit tracker for one untrusted-code region; flags the
// region-local violations and latches the caller stack frame base.
module ucca_region_fsm
    import ucca_pkg::*;
(
    input  logic        clk,
    input  logic        system_reset,
    input  logic        force_out,
    input  logic        active,
    input  logic        inst_changed,
    input  logic [15:0] pc,
    input  logic [15:0] prev_pc,
    input  logic [15:0] ucc_min,
    input  logic [15:0] ucc_max,
    input  logic [15:0] stack_pointer,
    input  logic        data_write,
    input  logic [15:0] data_addr,
    input  logic        irq_jmp,
    output logic        entry_viol,
    output logic        exit_viol,
    output logic        irq_viol,
    output logic        stack_viol
);

    region_state_e state_q;
    region_state_e state_d;
    logic [15:0]   base_q;
    logic          enter;
    logic          in_range;

    assign in_range = (pc >= ucc_min) && (pc <= ucc_max);

    always_comb begin
        state_d    = state_q;
        enter      = 1'b0;
        entry_viol = 1'b0;
        exit_viol  = 1'b0;
        irq_viol   = 1'b0;
        stack_viol = 1'b0;
        if (!active) begin
            state_d = OUTSIDE;
        end else begin
            unique case (state_q)
                OUTSIDE: begin
                    if (inst_changed) begin
                        if (pc == ucc_min) begin
                            state_d = INSIDE;
                            enter   = 1'b1;
                        end else if (in_range) begin
                            entry_viol = 1'b1;
                        end
                    end
                end
                INSIDE: begin
                    irq_viol   = irq_jmp;
                    stack_viol = data_write && (data_addr >= base_q);
                    // Leaving is legal only from the region's last instruction
                    if (inst_changed && !in_range) begin
                        state_d   = OUTSIDE;
                        exit_viol = (prev_pc != ucc_max);
                    end
                end
                default: state_d = OUTSIDE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_q <= OUTSIDE;
            base_q  <= '0;
        end else begin
            state_q <= force_out ? OUTSIDE : state_d;
            if (enter) begin
                base_q <= stack_pointer;
            end
        end
    end

endmodule

// File: rtl/ucca_monitor_n.sv
// Parametrised UCCA monitor: per-region trackers, configuration write
// guard, prioritised cause selection, stretched reset and sticky status.
module ucca_monitor_n
    import ucca_pkg::*;
#(
    parameter int          NUM_REGIONS = 3,
    parameter int          IDX_W       = 3,
    parameter logic [15:0] META_MIN    = META_MIN_DEFAULT,
    parameter logic [15:0] META_MAX    = META_MAX_DEFAULT,
    parameter int          RESET_HOLD  = 4,
    parameter int          CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      system_reset,
    input  logic [15:0]               pc,
    input  logic                      data_en,
    input  logic                      data_wr,
    input  logic [15:0]               data_addr,
    input  logic [15:0]               stack_pointer,
    input  logic                      irq_jmp,
    input  logic [16*NUM_REGIONS-1:0] ucc_min,
    input  logic [16*NUM_REGIONS-1:0] ucc_max,
    input  logic [NUM_REGIONS-1:0]    region_en,
    input  logic                      status_clr,
    output logic                      reset,
    output logic [2:0]                viol_cause,
    output logic [IDX_W-1:0]          viol_region,
    output logic [CNT_W-1:0]          viol_count
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    logic [15:0]            prev_pc;
    logic                   inst_changed;
    logic                   data_write;
    logic                   cfg_viol;
    logic                   viol_event;
    logic [2:0]             cause;
    logic [IDX_W-1:0]       region;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [NUM_REGIONS-1:0] entry_v;
    logic [NUM_REGIONS-1:0] exit_v;
    logic [NUM_REGIONS-1:0] irq_v;
    logic [NUM_REGIONS-1:0] stack_v;

    assign inst_changed = (pc != prev_pc);
    assign data_write   = data_en & data_wr;
    assign cfg_viol     = data_write && (data_addr >= META_MIN)
                          && (data_addr <= META_MAX);

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        logic active;
        assign active = region_en[g]
                        && (ucc_min[16*g +: 16] <= ucc_max[16*g +: 16]);
        ucca_region_fsm u_fsm (
            .clk           (clk),
            .system_reset  (system_reset),
            .force_out     (viol_event),
            .active        (active),
            .inst_changed  (inst_changed),
            .pc            (pc),
            .prev_pc       (prev_pc),
            .ucc_min       (ucc_min[16*g +: 16]),
            .ucc_max       (ucc_max[16*g +: 16]),
            .stack_pointer (stack_pointer),
            .data_write    (data_write),
            .data_addr     (data_addr),
            .irq_jmp       (irq_jmp),
            .entry_viol    (entry_v[g]),
            .exit_viol     (exit_v[g]),
            .irq_viol      (irq_v[g]),
            .stack_viol    (stack_v[g])
        );
    end

    function automatic logic [IDX_W-1:0] first_set(
        input logic [NUM_REGIONS-1:0] v
    );
        first_set = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDX_W'(i);
        end
    endfunction

    always_comb begin
        cause  = CAUSE_NONE;
        region = '0;
        if (cfg_viol) begin
            cause = CAUSE_CFG;
        end else if (|entry_v) begin
            cause  = CAUSE_ENTRY;
            region = first_set(entry_v);
        end else if (|exit_v) begin
            cause  = CAUSE_EXIT;
            region = first_set(exit_v);
        end else if (|irq_v) begin
            cause  = CAUSE_IRQ;
            region = first_set(irq_v);
        end else if (|stack_v) begin
            cause  = CAUSE_STACK;
            region = first_set(stack_v);
        end
    end

    assign viol_event = (cause != CAUSE_NONE);

    always_ff @(posedge clk) begin
        if (system_reset) prev_pc <= '0;
        else              prev_pc <= pc;
    end

    // A lone system_reset is our own pulse coming back and must not cut it
    // short; reset together with status_clr is the power-on sequence.
    always_ff @(posedge clk) begin
        if (viol_event) begin
            reset    <= 1'b1;
            hold_cnt <= HOLD_W'(RESET_HOLD - 1);
        end else if (system_reset && status_clr) begin
            reset    <= 1'b0;
            hold_cnt <= '0;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end else begin
            reset <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (viol_event) begin
            if (status_clr)       viol_count <= CNT_W'(1);
            else if (~&viol_count) viol_count <= viol_count + CNT_W'(1);
            if (status_clr || viol_cause == CAUSE_NONE) begin
                viol_cause  <= cause;
                viol_region <= region;
            end
        end else if (status_clr) begin
            viol_cause  <= CAUSE_NONE;
            viol_region <= '0;
            viol_count  <= '0;
        end
    end

endmodule

// File: tb/tb_ucca_monitor_n.sv
// Directed walk through the main scenarios followed by a random phase,
// every cycle compared against a rule-level reference model.
module tb_ucca_monitor_n;

    localparam int NR         = 3;
    localparam int RESET_HOLD = 4;

    logic          clk = 1'b0;
    logic          system_reset;
    logic [15:0]   pc;
    logic          data_en;
    logic          data_wr;
    logic [15:0]   data_addr;
    logic [15:0]   stack_pointer;
    logic          irq_jmp;
    logic [16*NR-1:0] ucc_min;
    logic [16*NR-1:0] ucc_max;
    logic [NR-1:0] region_en;
    logic          status_clr;
    logic          reset;
    logic [2:0]    viol_cause;
    logic [2:0]    viol_region;
    logic [7:0]    viol_count;

    int n_pass  = 0;
    int n_total = 0;

    bit          m_in[NR];
    logic [15:0] m_bp[NR];
    logic [15:0] m_prev;
    int          m_rem;
    int          m_cnt;
    int          m_cause;
    int          m_reg;

    always #5 clk = ~clk;

    ucca_monitor_n #(
        .NUM_REGIONS (NR),
        .IDX_W       (3),
        .META_MIN    (16'h0140),
        .META_MAX    (16'h016A),
        .RESET_HOLD  (RESET_HOLD),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .system_reset  (system_reset),
        .pc            (pc),
        .data_en       (data_en),
        .data_wr       (data_wr),
        .data_addr     (data_addr),
        .stack_pointer (stack_pointer),
        .irq_jmp       (irq_jmp),
        .ucc_min       (ucc_min),
        .ucc_max       (ucc_max),
        .region_en     (region_en),
        .status_clr    (status_clr),
        .reset         (reset),
        .viol_cause    (viol_cause),
        .viol_region   (viol_region),
        .viol_count    (viol_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      tag, got, exp, $time);
    endtask

    // Reference: apply the monitor rules to the inputs seen at this edge.
    task automatic model_step();
        bit          chg;
        bit          fl[6][NR];
        bit          nin[NR];
        logic [15:0] nbp[NR];
        logic [15:0] mn;
        logic [15:0] mx;
        bit          wr;
        int          cause;
        int          reg_i;
        chg   = (pc != m_prev);
        wr    = data_en && data_wr;
        cause = 0;
        reg_i = 0;
        for (int c = 0; c < 6; c++)
            for (int i = 0; i < NR; i++) fl[c][i] = 0;
        for (int i = 0; i < NR; i++) begin
            mn     = ucc_min[16*i +: 16];
            mx     = ucc_max[16*i +: 16];
            nin[i] = m_in[i];
            nbp[i] = m_bp[i];
            if (!(region_en[i] && mn <= mx)) begin
                nin[i] = 0;
            end else if (!m_in[i]) begin
                if (chg && pc == mn) begin
                    nin[i] = 1;
                    nbp[i] = stack_pointer;
                end else if (chg && pc > mn && pc <= mx) begin
                    fl[2][i] = 1;
                end
            end else begin
                if (irq_jmp) fl[4][i] = 1;
                if (wr && data_addr >= m_bp[i]) fl[5][i] = 1;
                if (chg && (pc < mn || pc > mx)) begin
                    nin[i] = 0;
                    if (m_prev != mx) fl[3][i] = 1;
                end
            end
        end
        if (wr && data_addr >= 16'h0140 && data_addr <= 16'h016A) begin
            cause = 1;
        end else begin
            for (int c = 2; c < 6; c++)
                for (int i = 0; i < NR; i++)
                    if (cause == 0 && fl[c][i]) begin
                        cause = c;
                        reg_i = i;
                    end
        end
        if (cause != 0)                     m_rem = RESET_HOLD;
        else if (system_reset && status_clr) m_rem = 0;
        else if (m_rem > 0)                 m_rem = m_rem - 1;
        if (cause != 0) begin
            m_cnt = status_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            if (status_clr || m_cause == 0) begin
                m_cause = cause;
                m_reg   = reg_i;
            end
        end else if (status_clr) begin
            m_cnt   = 0;
            m_cause = 0;
            m_reg   = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (system_reset) begin
                m_in[i] = 0;
                m_bp[i] = 16'h0000;
            end else begin
                m_in[i] = (cause != 0) ? 1'b0 : nin[i];
                m_bp[i] = nbp[i];
            end
        end
        m_prev = system_reset ? 16'h0000 : pc;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("reset",  32'(reset),       32'(m_rem > 0));
        chk("cause",  32'(viol_cause),  32'(m_cause));
        chk("region", 32'(viol_region), 32'(m_reg));
        chk("count",  32'(viol_count),  32'(m_cnt));
    endtask

    task automatic drain();
        data_en = 0; data_wr = 0; irq_jmp = 0; status_clr = 0;
        repeat (RESET_HOLD + 2) step();
    endtask

    task automatic set_region(input int i, input logic [15:0] mn,
                              input logic [15:0] mx);
        ucc_min[16*i +: 16] = mn;
        ucc_max[16*i +: 16] = mx;
    endtask

    task automatic write(input logic [15:0] a);
        data_en = 1; data_wr = 1; data_addr = a;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_in[i] = 0;
            m_bp[i] = 16'h0000;
        end
        m_prev = 16'h0000; m_rem = 0; m_cnt = 0; m_cause = 0; m_reg = 0;
        pc = 16'h0000; data_en = 0; data_wr = 0; data_addr = 16'h0000;
        stack_pointer = 16'h0400; irq_jmp = 0; region_en = '0;
        ucc_min = '0; ucc_max = '0;
        system_reset = 1; status_clr = 1;
        step();
        system_reset = 0; status_clr = 0;
        chk("por_reset", 32'(reset), 0);
        chk("por_cause", 32'(viol_cause), 0);
        chk("por_count", 32'(viol_count), 0);

        set_region(0, 16'hE000, 16'hE0FE);
        set_region(1, 16'hE200, 16'hE2FE);
        set_region(2, 16'hE400, 16'hE403);
        region_en = 3'b111;

        pc = 16'hC000; step();
        pc = 16'hE000; step();
        pc = 16'hE002; step();
        pc = 16'hE0FE; step();
        pc = 16'hC010; step();
        chk("legal_walk_reset", 32'(reset), 0);
        chk("legal_walk_count", 32'(viol_count), 0);

        pc = 16'hC000; step();
        pc = 16'hE010; step();
        chk("mid_entry_cause", 32'(viol_cause), 2);
        chk("mid_entry_region", 32'(viol_region), 0);
        chk("mid_entry_count", 32'(viol_count), 1);
        chk("mid_entry_reset", 32'(reset), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_len", 32'(reset), 32'(k < 3));
        end

        status_clr = 1; pc = 16'hC000; step();
        status_clr = 0; stack_pointer = 16'h0400; pc = 16'hE200; step();
        pc = 16'hE202; step();
        write(16'h0150); irq_jmp = 1; step();
        chk("cfg_prio_cause", 32'(viol_cause), 1);
        chk("cfg_prio_region", 32'(viol_region), 0);
        data_en = 0; data_wr = 0; irq_jmp = 0; step();
        write(16'h0150); step();
        chk("second_cause", 32'(viol_cause), 1);
        chk("second_count", 32'(viol_count), 2);
        for (int k = 0; k < 4; k++) begin
            data_en = 0; data_wr = 0;
            step();
            chk("extend_hold", 32'(reset), 32'(k < 3));
        end

        status_clr = 1; pc = 16'hC000; step();
        status_clr = 0; pc = 16'hE200; stack_pointer = 16'h0400; step();
        stack_pointer = 16'h03E0; write(16'h0402); step();
        chk("stack_cause", 32'(viol_cause), 5);
        chk("stack_region", 32'(viol_region), 1);
        drain();

        status_clr = 1; pc = 16'hC000; step();
        status_clr = 0; pc = 16'hE400; step();
        irq_jmp = 1; step();
        chk("irq_cause", 32'(viol_cause), 4);
        chk("irq_region", 32'(viol_region), 2);
        irq_jmp = 0; status_clr = 1; step();
        status_clr = 0;
        chk("clr_cause", 32'(viol_cause), 0);
        chk("clr_count", 32'(viol_count), 0);
        chk("clr_keeps_reset", 32'(reset), 1);
        step(); step();
        chk("clr_pulse_tail", 32'(reset), 1);
        step();
        chk("clr_pulse_end", 32'(reset), 0);
        drain();

        region_en = 3'b101; pc = 16'hC000; step();
        pc = 16'hE210; step();
        chk("disabled_reset", 32'(reset), 0);
        pc = 16'hC000; set_region(2, 16'hE403, 16'hE400); step();
        pc = 16'hE401; step();
        chk("inverted_reset", 32'(reset), 0);
        chk("inverted_count", 32'(viol_count), 0);
        pc = 16'hC000; step();

        status_clr = 1;
        for (int k = 0; k < 300; k++) begin
            write(16'h0150); step();
            status_clr = 0;
        end
        chk("sat_count", 32'(viol_count), 255);
        chk("sat_cause", 32'(viol_cause), 1);
        data_en = 0; data_wr = 0;
        for (int k = 0; k < 4; k++) begin
            system_reset = (k == 0);
            step();
            chk("sysrst_hold", 32'(reset), 32'(k < 3));
        end
        system_reset = 0;
        chk("sysrst_keeps_count", 32'(viol_count), 255);

        region_en = 3'b111;
        set_region(2, 16'hE400, 16'hE400);
        status_clr = 1; step();
        for (int n = 0; n < 3000; n++) begin
            automatic int          r = $urandom_range(0, 9);
            automatic int          g = $urandom_range(0, NR - 1);
            automatic logic [15:0] mn = ucc_min[16*g +: 16];
            automatic logic [15:0] mx = ucc_max[16*g +: 16];
            case (r)
                3: pc = mn;
                4, 9: pc = mx;
                5: pc = mn + 16'($urandom_range(1, 3));
                6: pc = mx + 16'd2;
                7: pc = 16'hC000 + 16'($urandom_range(0, 255));
                8: pc = pc + 16'd2;
                default: ;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                region_en = 3'($urandom);
                if ($urandom_range(0, 1) == 1)
                    set_region(1, 16'hE2FE, 16'hE200);
                else
                    set_region(1, 16'hE200, 16'hE2FE);
            end
            case ($urandom_range(0, 2))
                0: stack_pointer = 16'h0300;
                1: stack_pointer = 16'h0400;
                default: stack_pointer = 16'h0500;
            endcase
            data_en = ($urandom_range(0, 5) == 0);
            data_wr = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0: data_addr = 16'h0150;
                1: data_addr = 16'h0140;
                2: data_addr = 16'h016A;
                3: data_addr = 16'h016B;
                4: data_addr = 16'h013F;
                5: data_addr = 16'h0402;
                6: data_addr = 16'h0300;
                default: data_addr = 16'($urandom);
            endcase
            irq_jmp      = ($urandom_range(0, 29) == 0);
            status_clr   = ($urandom_range(0, 59) == 0);
            system_reset = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
